// File: rtl/matmul_seq.sv
// matmul_seq: Decode-stage sequencer that diverts fetch into microcode on
// STARTMATMUL2 and returns to the saved program PC on ENDMATMUL.
// Optional watchdog is built when the macro MATMUL_WDT_EN is defined; it
// forces the return path if the microcode routine never issues ENDMATMUL.
module matmul_seq #(
  parameter logic [31:0] UCODE_BASE = 32'h0000_0000,
  parameter int unsigned WDT_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic        valid_d,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        im_sel,
  output logic [31:0] pc_backup,
  output logic        fsm_state,
  output logic        err,
  output logic        wdt_to
);

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_MATMUL2 = 1'b1
  } state_t;

  localparam logic [6:0] MATMUL_OPC = 7'b1111010;

  state_t      state_q, state_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] pc_backup_q, pc_backup_d;
  logic        err_q, err_d;

  logic accepted, is_start, is_end, start_acc, end_acc, wdt_fire;

  // Only opcode and funct3 participate in decoding.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_d[31:15], instr_d[11:7]};

  // The cycle right after a redirect carries a wrong-path instruction, so
  // it is never accepted.
  assign accepted  = valid_d & ~stall_d & ~flush_d & ~redirect_q;
  assign is_start  = (instr_d[6:0] == MATMUL_OPC) && (instr_d[14:12] == 3'b000);
  assign is_end    = (instr_d[6:0] == MATMUL_OPC) && (instr_d[14:12] == 3'b111);
  assign start_acc = accepted & is_start;
  assign end_acc   = accepted & is_end;

`ifdef MATMUL_WDT_EN
  localparam logic [31:0] WDT_LIM = 32'(WDT_LIMIT);

  logic [31:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_to_q, wdt_to_d;

  // An ENDMATMUL arriving on the limit cycle wins: it is a normal exit.
  assign wdt_fire = (state_q == ST_MATMUL2) && (wdt_cnt_q >= WDT_LIM) && !end_acc;

  // Watchdog counter: cleared on entry, saturating count while in MATMUL2.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_to_d  = wdt_to_q;
    if (state_q == ST_NORMAL) begin
      if (start_acc) wdt_cnt_d = '0;
    end else if (wdt_cnt_q < WDT_LIM) begin
      wdt_cnt_d = wdt_cnt_q + 32'd1;
    end
    if (wdt_fire) wdt_to_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wdt_cnt_q <= '0;
      wdt_to_q  <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_to_q  <= wdt_to_d;
    end
  end

  assign wdt_to = wdt_to_q;
`else
  assign wdt_fire = 1'b0;
  assign wdt_to   = 1'b0;
`endif

  // Next-state logic: mode switches, redirect pulse, error flag.
  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    pc_backup_d   = pc_backup_q;
    err_d         = err_q;
    case (state_q)
      ST_NORMAL: begin
        if (start_acc) begin
          state_d       = ST_MATMUL2;
          redirect_d    = 1'b1;
          redirect_pc_d = UCODE_BASE;
          pc_backup_d   = pc_d + 32'd4;
        end else if (end_acc) begin
          err_d = 1'b1;
        end
      end
      ST_MATMUL2: begin
        // Nested entry is flagged but otherwise ignored.
        if (start_acc) err_d = 1'b1;
        if (end_acc || wdt_fire) begin
          state_d       = ST_NORMAL;
          redirect_d    = 1'b1;
          redirect_pc_d = pc_backup_q;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // State register; reset dominates everything and never emits a redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_NORMAL;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      pc_backup_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      pc_backup_q   <= pc_backup_d;
      err_q         <= err_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign pc_backup   = pc_backup_q;
  assign fsm_state   = state_q;
  assign im_sel      = state_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed scenarios plus randomized traffic against a
// transaction-level reference model of the MATMUL2 sequencer.
// Watchdog scenarios follow the MATMUL_WDT_EN macro.
module tb_matmul_seq;

  localparam logic [31:0] UCODE = 32'h0000_0800;
  localparam int          WLIM  = 8;
  localparam logic [31:0] I_START = 32'h0000_007A;
  localparam logic [31:0] I_END   = 32'h0000_707A;
  localparam logic [31:0] I_NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d, pc_d;
  logic        valid_d, stall_d, flush_d;
  logic        redirect, im_sel, fsm_state, err, wdt_to;
  logic [31:0] redirect_pc, pc_backup;

  int checks = 0;
  int errors = 0;

  // Reference model state (observable outputs after the most recent edge).
  logic        m_mode, m_redir, m_err, m_wdt;
  logic [31:0] m_rpc, m_backup;
  int          m_cycles_in;

`ifdef MATMUL_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  matmul_seq #(.UCODE_BASE(UCODE), .WDT_LIMIT(WLIM)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d),
    .valid_d(valid_d), .stall_d(stall_d), .flush_d(flush_d),
    .redirect(redirect), .redirect_pc(redirect_pc), .im_sel(im_sel),
    .pc_backup(pc_backup), .fsm_state(fsm_state), .err(err), .wdt_to(wdt_to)
  );

  always #5 clk = ~clk;

  // Model: what the sequencer must show after the coming edge.
  task automatic model_step();
    logic acc, st, en, timeout;
    if (!reset) begin
      m_mode = 0; m_redir = 0; m_err = 0; m_wdt = 0;
      m_rpc = 0; m_backup = 0; m_cycles_in = 0;
      return;
    end
    acc = valid_d && !stall_d && !flush_d && !m_redir;
    st  = acc && instr_d[6:0] == 7'h7A && instr_d[14:12] == 3'd0;
    en  = acc && instr_d[6:0] == 7'h7A && instr_d[14:12] == 3'd7;
    m_redir = 0;
    if (!m_mode) begin
      if (st) begin
        m_mode = 1; m_redir = 1; m_rpc = UCODE; m_backup = pc_d + 32'd4;
        m_cycles_in = 0;
      end else if (en) m_err = 1;
    end else begin
      timeout = WDT_ON && (m_cycles_in >= WLIM);
      if (st) m_err = 1;
      if (en || timeout) begin
        m_mode = 0; m_redir = 1; m_rpc = m_backup;
        if (!en) m_wdt = 1;
      end
      if (m_cycles_in < WLIM) m_cycles_in++;
    end
  endtask

  // Drive one Decode cycle, advance the model, and step past the edge.
  task automatic cycle(input logic [31:0] instr, input logic [31:0] pc,
                       input logic v, input logic s, input logic f);
    instr_d = instr; pc_d = pc; valid_d = v; stall_d = s; flush_d = f;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    cycle(I_START, 32'h10, 1, 0, 0);
    cycle(I_START, 32'h10, 1, 0, 0);
    checks++;
    if ({redirect, redirect_pc, im_sel, pc_backup, fsm_state, err, wdt_to} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs: got redirect=%b rpc=%h im_sel=%b backup=%h fsm=%b err=%b wdt=%b, required all 0",
               redirect, redirect_pc, im_sel, pc_backup, fsm_state, err, wdt_to);
    end
    reset = 1;
    cycle(I_NOP, 32'h0, 1, 0, 0);
    checks++;
    if (fsm_state !== 1'b0 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: fsm=%b redirect=%b, required 0 0", fsm_state, redirect);
    end
    $display("test_reset done");
  endtask

  task automatic test_start_end();
    cycle(I_START, 32'h10, 1, 0, 0);
    checks++;
    if ({redirect, redirect_pc, im_sel, pc_backup, fsm_state} !== {1'b1, UCODE, 1'b1, 32'h14, 1'b1}) begin
      errors++;
      $display("FAIL start_entry: redirect=%b rpc=%h im_sel=%b backup=%h fsm=%b, required 1 %h 1 00000014 1",
               redirect, redirect_pc, im_sel, pc_backup, fsm_state, UCODE);
    end
    // Wrong-path START right after the redirect must be ignored.
    cycle(I_START, 32'h40, 1, 0, 0);
    checks++;
    if ({redirect, redirect_pc, pc_backup, err} !== {1'b0, UCODE, 32'h14, 1'b0}) begin
      errors++;
      $display("FAIL start_wrong_path: redirect=%b rpc=%h backup=%h err=%b, required 0 %h 00000014 0",
               redirect, redirect_pc, pc_backup, err, UCODE);
    end
    cycle(I_NOP, UCODE + 4, 1, 0, 0);
    cycle(I_END, UCODE + 8, 1, 0, 0);
    checks++;
    if ({redirect, redirect_pc, im_sel, fsm_state, pc_backup} !== {1'b1, 32'h14, 1'b0, 1'b0, 32'h14}) begin
      errors++;
      $display("FAIL end_exit: redirect=%b rpc=%h im_sel=%b fsm=%b backup=%h, required 1 00000014 0 0 00000014",
               redirect, redirect_pc, im_sel, fsm_state, pc_backup);
    end
    cycle(I_END, UCODE + 12, 1, 0, 0);
    checks++;
    if ({redirect, err, redirect_pc} !== {1'b0, 1'b0, 32'h14}) begin
      errors++;
      $display("FAIL end_wrong_path: redirect=%b err=%b rpc=%h, required 0 0 00000014", redirect, err, redirect_pc);
    end
    $display("test_start_end done");
  endtask

  task automatic test_stall_flush();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(I_START, 32'h100, 1, 1, 0);
      if (redirect === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || fsm_state !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: pulses=%0d fsm=%b, required 0 0", pulses, fsm_state);
    end
    cycle(I_START, 32'h100, 1, 0, 0);
    if (redirect === 1'b1) pulses++;
    cycle(I_START, 32'h100, 1, 0, 0);
    if (redirect === 1'b1) pulses++;
    checks++;
    if (pulses !== 1 || pc_backup !== 32'h104 || fsm_state !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: pulses=%0d backup=%h fsm=%b err=%b, required 1 00000104 1 0",
               pulses, pc_backup, fsm_state, err);
    end
    cycle(I_END, UCODE, 1, 0, 0);
    cycle(I_NOP, 32'h104, 1, 0, 0);
    cycle(I_START, 32'h200, 1, 0, 1);
    cycle(I_START, 32'h200, 1, 1, 1);
    cycle(I_START, 32'h200, 0, 0, 0);
    checks++;
    if (redirect !== 1'b0 || fsm_state !== 1'b0 || pc_backup !== 32'h104) begin
      errors++;
      $display("FAIL flush_ignore: redirect=%b fsm=%b backup=%h, required 0 0 00000104",
               redirect, fsm_state, pc_backup);
    end
    $display("test_stall_flush done");
  endtask

  task automatic test_errors();
    cycle(I_END, 32'h300, 1, 0, 0);
    checks++;
    if ({err, redirect, fsm_state} !== 3'b100) begin
      errors++;
      $display("FAIL end_in_normal: err=%b redirect=%b fsm=%b, required 1 0 0", err, redirect, fsm_state);
    end
    reset = 0; cycle(I_NOP, 0, 1, 0, 0); reset = 1;
    cycle(I_START, 32'h400, 1, 0, 0);
    cycle(I_NOP, UCODE, 1, 0, 0);
    cycle(32'h0000_307A, UCODE + 4, 1, 0, 0);
    checks++;
    if (err !== 1'b0 || fsm_state !== 1'b1) begin
      errors++;
      $display("FAIL other_funct3: err=%b fsm=%b, required 0 1", err, fsm_state);
    end
    cycle(I_START, 32'h500, 1, 0, 0);
    checks++;
    if ({err, redirect, fsm_state, im_sel, pc_backup} !== {4'b1011, 32'h404}) begin
      errors++;
      $display("FAIL nested_start: err=%b redirect=%b fsm=%b im_sel=%b backup=%h, required 1 0 1 1 00000404",
               err, redirect, fsm_state, im_sel, pc_backup);
    end
    cycle(I_END, UCODE + 8, 1, 0, 0);
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h404) begin
      errors++;
      $display("FAIL nested_exit: redirect=%b rpc=%h, required 1 00000404", redirect, redirect_pc);
    end
    cycle(I_NOP, 32'h404, 1, 0, 0);
    $display("test_errors done");
  endtask

  task automatic test_watchdog();
    int seen = 0;
    reset = 0; cycle(I_NOP, 0, 1, 0, 0); reset = 1;
    cycle(I_START, 32'h600, 1, 0, 0);
    for (int j = 1; j <= 20; j++) begin
      cycle(I_NOP, UCODE, 1, 0, 0);
      if (redirect === 1'b1 && seen == 0) seen = j;
    end
    checks++;
    if (WDT_ON) begin
      if (seen !== 9 || wdt_to !== 1'b1 || fsm_state !== 1'b0 || redirect_pc !== 32'h604) begin
        errors++;
        $display("FAIL wdt_timeout: exit_after=%0d wdt_to=%b fsm=%b rpc=%h, required 9 1 0 00000604",
                 seen, wdt_to, fsm_state, redirect_pc);
      end
      // ENDMATMUL on the limit cycle is a normal exit.
      reset = 0; cycle(I_NOP, 0, 1, 0, 0); reset = 1;
      cycle(I_START, 32'h700, 1, 0, 0);
      for (int j = 0; j < WLIM; j++) cycle(I_NOP, UCODE, 1, 0, 0);
      cycle(I_END, UCODE, 1, 0, 0);
      checks++;
      if ({redirect, wdt_to, fsm_state, redirect_pc} !== {3'b100, 32'h704}) begin
        errors++;
        $display("FAIL wdt_end_race: redirect=%b wdt_to=%b fsm=%b rpc=%h, required 1 0 0 00000704",
                 redirect, wdt_to, fsm_state, redirect_pc);
      end
    end else begin
      if (seen !== 0 || wdt_to !== 1'b0 || fsm_state !== 1'b1) begin
        errors++;
        $display("FAIL no_wdt_stay: exit_after=%0d wdt_to=%b fsm=%b, required 0 0 1", seen, wdt_to, fsm_state);
      end
      cycle(I_END, UCODE, 1, 0, 0);
    end
    cycle(I_NOP, 0, 1, 0, 0);
    $display("test_watchdog done");
  endtask

  task automatic test_reset_in_matmul();
    cycle(I_START, 32'h900, 1, 0, 0);
    cycle(I_NOP, UCODE, 1, 0, 0);
    reset = 0;
    cycle(I_END, UCODE, 1, 0, 0);
    checks++;
    if ({redirect, redirect_pc, im_sel, pc_backup, fsm_state, err, wdt_to} !== 68'd0) begin
      errors++;
      $display("FAIL reset_in_matmul: redirect=%b rpc=%h im_sel=%b backup=%h fsm=%b err=%b wdt=%b, required all 0",
               redirect, redirect_pc, im_sel, pc_backup, fsm_state, err, wdt_to);
    end
    reset = 1;
    cycle(I_NOP, 0, 1, 0, 0);
    checks++;
    if (redirect !== 1'b0 || fsm_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse: redirect=%b fsm=%b, required 0 0", redirect, fsm_state);
    end
    $display("test_reset_in_matmul done");
  endtask

  task automatic test_random();
    logic [31:0] r, instr;
    logic [68:0] act, exp;
    int bad = 0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: instr = {r[31:15], 3'b000, r[11:7], 7'h7A};
        1: instr = {r[31:15], 3'b111, r[11:7], 7'h7A};
        2: instr = {r[31:15], 3'($urandom_range(1, 6)), r[11:7], 7'h7A};
        default: instr = r;
      endcase
      reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      cycle(instr, $urandom, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0);
      act = {redirect, redirect_pc, im_sel, pc_backup, fsm_state, err, wdt_to};
      exp = {m_redir, m_rpc, m_mode, m_backup, m_mode, m_err, m_wdt};
      checks++;
      if (act !== exp) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle_%0d: got %h, required %h (redirect,rpc,im_sel,backup,fsm,err,wdt)",
                   n, act, exp);
      end
    end
    reset = 1;
    $display("test_random done");
  endtask

  initial begin
    reset = 0; instr_d = 0; pc_d = 0; valid_d = 0; stall_d = 0; flush_d = 0;
    test_reset();
    test_start_end();
    test_stall_flush();
    test_errors();
    test_watchdog();
    test_reset_in_matmul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
